ssm_tile_scheduler: RTL

- Sequences the SSM block datapath: fetches B/C/hprev tiles and per-group scalars (dt, dA, x, D) from the on-chip tile buffers, and streams them into the datapath as back-to-back tiles.
- Limits the number of groups in flight with a credit counter.
- Collects each y_final result and writes it in order into the output buffer.
- One group = N_TOTAL/N_TILE tiles = one (h,p) element.

---
 rtl/ssm_tile_scheduler_if.sv | 50 +++++
 rtl/ssm_tile_scheduler.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ssm_tile_scheduler_if.sv
// Tile-buffer read, datapath tile stream and y_final return/write bundle
// shared by the SSM tile scheduler and its surrounding datapath.
interface ssm_tile_scheduler_if #(
  parameter int GRP_W = 12,
  parameter int TB    = 3,
  parameter int DW    = 16
);
  logic                rd_en_o;
  logic [GRP_W+TB-1:0] rd_tile_addr_o;
  logic [GRP_W-1:0]    rd_grp_o;
  logic                tile_ready_i;
  logic                tile_valid_o;
  logic                tile_first_o;
  logic                tile_last_o;
  logic [DW-1:0]       y_i;
  logic                y_valid_i;
  logic                y_wr_en_o;
  logic [GRP_W-1:0]    y_wr_addr_o;
  logic [DW-1:0]       y_wr_data_o;

  modport master (
    output rd_en_o,
    output rd_tile_addr_o,
    output rd_grp_o,
    input  tile_ready_i,
    output tile_valid_o,
    output tile_first_o,
    output tile_last_o,
    input  y_i,
    input  y_valid_i,
    output y_wr_en_o,
    output y_wr_addr_o,
    output y_wr_data_o
  );

  modport slave (
    input  rd_en_o,
    input  rd_tile_addr_o,
    input  rd_grp_o,
    output tile_ready_i,
    input  tile_valid_o,
    input  tile_first_o,
    input  tile_last_o,
    output y_i,
    output y_valid_i,
    input  y_wr_en_o,
    input  y_wr_addr_o,
    input  y_wr_data_o
  );
endinterface

// File: rtl/ssm_tile_scheduler.sv
// SSM tile scheduler: issues B/C/hprev tiles per group under a credit
// limit, delays them by the buffer read latency, writes y_final in order.
module ssm_tile_scheduler #(
  parameter int N_TILE       = 16,
  parameter int N_TOTAL      = 128,
  parameter int DW           = 16,
  parameter int GRP_W        = 12,
  parameter int MAX_INFLIGHT = 4,
  parameter int RD_LAT       = 2,
  localparam int TPG         = N_TOTAL / N_TILE,
  localparam int TB          = $clog2(TPG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [GRP_W-1:0]     num_grp_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  ssm_tile_scheduler_if.master bus
);

  localparam logic [3:0]    MAX_C   = 4'(MAX_INFLIGHT);
  localparam logic [TB-1:0] TILE_LS = TB'(TPG - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [GRP_W-1:0] num_grp_q;
  logic [GRP_W-1:0] issue_grp_q;
  logic [GRP_W-1:0] ret_cnt_q;
  logic [TB-1:0]    tile_cnt_q;
  logic [3:0]       inflight_q;
  logic             err_q;

  logic [RD_LAT-1:0] pv_q;
  logic [RD_LAT-1:0] pf_q;
  logic [RD_LAT-1:0] pl_q;

  logic             wr_en_q;
  logic [GRP_W-1:0] wr_addr_q;
  logic [DW-1:0]    wr_data_q;

  logic start_ok;
  logic issue;
  logic tile0;
  logic tile_end;
  logic grp_end;
  logic ret_ok;
  logic ret_bad;
  logic ret_all;

  assign tile0    = tile_cnt_q == '0;
  assign tile_end = tile_cnt_q == TILE_LS;
  assign grp_end  = issue_grp_q == num_grp_q - GRP_W'(1);

  // A result is only legal while a group is outstanding.
  assign ret_ok  = bus.y_valid_i && (inflight_q != '0)
                   && (ret_cnt_q != num_grp_q);
  assign ret_bad = bus.y_valid_i && !ret_ok;

  // Look ahead so DONE lines up with the write of the final result.
  assign ret_all = (ret_cnt_q == num_grp_q)
                   || (ret_ok && (ret_cnt_q + GRP_W'(1) == num_grp_q));

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    issue    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          start_ok = 1'b1;
          // An empty job still spends one cycle busy before DONE.
          state_d  = (num_grp_i == '0) ? S_DRAIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        issue = bus.tile_ready_i && (!tile0 || (inflight_q < MAX_C));
        if (issue && tile_end && grp_end) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (ret_all) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_grp_q   <= '0;
      issue_grp_q <= '0;
      tile_cnt_q  <= '0;
      inflight_q  <= '0;
      ret_cnt_q   <= '0;
    end else if (start_ok) begin
      num_grp_q   <= num_grp_i;
      issue_grp_q <= '0;
      tile_cnt_q  <= '0;
      inflight_q  <= '0;
      ret_cnt_q   <= '0;
    end else begin
      if (issue) begin
        tile_cnt_q <= tile_cnt_q + TB'(1);
        if (tile_end) begin
          issue_grp_q <= issue_grp_q + GRP_W'(1);
        end
      end
      case ({issue && tile0, ret_ok})
        2'b10:   inflight_q <= inflight_q + 4'd1;
        2'b01:   inflight_q <= inflight_q - 4'd1;
        default: inflight_q <= inflight_q;
      endcase
      if (ret_ok) begin
        ret_cnt_q <= ret_cnt_q + GRP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (start_ok) begin
      err_q <= 1'b0;
    end else if (ret_bad) begin
      err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= ret_ok;
      if (ret_ok) begin
        wr_addr_q <= ret_cnt_q;
        wr_data_q <= bus.y_i;
      end
    end
  end

  // Read-latency pipe; never stalled by tile_ready_i.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv_q <= '0;
      pf_q <= '0;
      pl_q <= '0;
    end else begin
      pv_q[0] <= issue;
      pf_q[0] <= issue && tile0;
      pl_q[0] <= issue && tile_end;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pf_q[i] <= pf_q[i-1];
        pl_q[i] <= pl_q[i-1];
      end
    end
  end

  assign busy_o = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done_o = state_q == S_DONE;
  assign err_o  = err_q;

  assign bus.rd_en_o        = issue;
  assign bus.rd_tile_addr_o = {issue_grp_q, tile_cnt_q};
  assign bus.rd_grp_o       = issue_grp_q;
  assign bus.tile_valid_o   = pv_q[RD_LAT-1];
  assign bus.tile_first_o   = pf_q[RD_LAT-1];
  assign bus.tile_last_o    = pl_q[RD_LAT-1];
  assign bus.y_wr_en_o      = wr_en_q;
  assign bus.y_wr_addr_o    = wr_addr_q;
  assign bus.y_wr_data_o    = wr_data_q;

endmodule
